ctr_mode_iter: RTL

//  Counter-mode (CTR) wrapper around the iterative block cipher core encrypt_iter.
//  - Builds the counter block {nonce, ctr} and drives it to the core via its 4-phase req/ack handshake.
//  - XORs the returned keystream block with one plaintext block.
//  - Emits the ciphertext block on a valid/ready stream.
//  - Sits directly upstream (feeds k, m) and downstream (consumes c) of the core.
//  - Encryption and decryption are the same operation.

---
 rtl/ctr_mode_iter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ctr_mode_iter.sv
// -----------------------------------------------------------------------------
// ctr_mode_iter
//   Counter-mode (CTR) wrapper around the iterative block cipher core.
//   The counter block {nonce_q, ctr_q} is presented to the core over a 4-phase
//   req/ack handshake. The returned keystream block is XORed with one
//   plaintext block, and the result is emitted on a valid/ready stream.
//   Encryption and decryption are the same operation.
//
// Ports
//   clk, rst        clock and synchronous active-high reset (shared with core)
//   init            pulse: latch key/nonce, clear ctr and wrapped (IDLE only)
//   key, nonce      session key / nonce, sampled on init
//   p_data/p_valid/p_ready   plaintext block stream in
//   o_data/o_valid/o_ready   ciphertext block stream out
//   wrapped         sticky: counter rolled over from all-ones to zero
//   e_k, e_m, e_req to the core (key, counter block, request)
//   e_ack, e_c      from the core (acknowledge, keystream block)
// -----------------------------------------------------------------------------
module ctr_mode_iter #(
    parameter int  N_B   = 64,
    parameter int  N_K   = 128,
    parameter int  CTR_W = 32,
    localparam int N_N   = N_B - CTR_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init,
    input  logic [N_K-1:0] key,
    input  logic [N_N-1:0] nonce,
    input  logic [N_B-1:0] p_data,
    input  logic           p_valid,
    output logic           p_ready,
    output logic [N_B-1:0] o_data,
    output logic           o_valid,
    input  logic           o_ready,
    output logic           wrapped,
    output logic [N_K-1:0] e_k,
    output logic [N_B-1:0] e_m,
    output logic           e_req,
    input  logic           e_ack,
    input  logic [N_B-1:0] e_c
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        OUT
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [N_K-1:0]   key_q;
    logic [N_N-1:0]   nonce_q;
    logic [CTR_W-1:0] ctr_q;
    logic [N_B-1:0]   p_q;
    logic [N_B-1:0]   ks_q;

    logic             load_session;
    logic             accept;
    logic             capture_ks;
    logic             emit;

    // Next-state and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state   = state;
        load_session = 1'b0;
        accept       = 1'b0;
        capture_ks   = 1'b0;
        emit         = 1'b0;
        unique case (state)
            IDLE: begin
                // init wins over p_valid; the block is not taken that cycle.
                if (init) begin
                    load_session = 1'b1;
                end else if (p_valid) begin
                    accept     = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                if (e_ack) begin
                    capture_ks = 1'b1;
                    next_state = DROP;
                end
            end
            DROP: begin
                // Complete the 4-phase handshake before the next request can
                // ever be raised.
                if (!e_ack) begin
                    emit       = 1'b1;
                    next_state = OUT;
                end
            end
            OUT: begin
                if (o_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state   <= IDLE;
            key_q   <= '0;
            nonce_q <= '0;
            ctr_q   <= '0;
            p_q     <= '0;
            ks_q    <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            e_req   <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            state   <= next_state;
            // Handshake outputs are registered copies of the next state, so no
            // combinational path exists from e_ack/e_c to any output.
            e_req   <= (next_state == REQ);
            o_valid <= (next_state == OUT);

            if (load_session) begin
                key_q   <= key;
                nonce_q <= nonce;
                ctr_q   <= '0;
                wrapped <= 1'b0;
            end
            if (accept) begin
                p_q <= p_data;
            end
            if (capture_ks) begin
                ks_q <= e_c;
            end
            if (emit) begin
                o_data <= ks_q ^ p_q;
                ctr_q  <= ctr_q + CTR_W'(1);
                if (&ctr_q) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

    assign p_ready = (state == IDLE);
    assign e_k     = key_q;
    assign e_m     = {nonce_q, ctr_q};

endmodule
